// File: rtl/ad9361_spi_sched_if.sv
// Request/response bus of the dual-AD9361 SPI scheduler.
// Handshake: a command on requester i is taken on the one cycle where req_valid[i] and req_ready[i] are both high; rsp_valid is a one-cycle strobe that is never back-pressured.
interface ad9361_spi_sched_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_chip;
    logic [1:0]  req_rnw;
    logic [19:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_id;
    logic [7:0]  rsp_data;
    logic        busy;

    modport master (
        output req_valid, req_chip, req_rnw, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_id, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_chip, req_rnw, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/ad9361_spi_sched.sv
// Shared SPI master for the two AD9361 transceivers with a two-requester
// round-robin scheduler; one 24-bit single-byte transaction at a time.
module ad9361_spi_sched #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 4
) (
    input  logic               clk,
    input  logic               rst,
    ad9361_spi_sched_if.slave  bus,
    output logic               a_spi_sck,
    output logic               a_spi_di,
    output logic               a_spi_cs,
    input  logic               a_spi_do,
    output logic               b_spi_sck,
    output logic               b_spi_di,
    output logic               b_spi_cs,
    input  logic               b_spi_do,
    output logic [2:0]         state_dbg
);
    function automatic int max_of(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    localparam int CNT_MAX = max_of(max_of(max_of(2 * CLK_DIV, CS_SETUP),
                                           max_of(CS_HOLD, CS_GAP)), 24);
    localparam int CW = $clog2(CNT_MAX + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] bit_cnt;
    logic          ptr;
    logic          gnt_id;
    logic          chip;
    logic          rnw;
    logic [23:0]   shreg;
    logic [7:0]    rdata;
    logic          rsp_valid_q;
    logic          rsp_id_q;
    logic [7:0]    rsp_data_q;

    logic          gnt;
    logic          grant_now;
    logic          sel_chip;
    logic          sel_rnw;
    logic [9:0]    sel_addr;
    logic [7:0]    sel_wdata;
    logic          active;
    logic          sck_int;
    logic          di_int;
    logic          sdo;

    // The pointer names the requester that wins when both are asking.
    always_comb begin
        gnt = 1'b0;
        if (bus.req_valid == 2'b11) gnt = ptr;
        else                        gnt = bus.req_valid[1];
    end

    assign grant_now     = (state == S_IDLE) && !rst && (bus.req_valid != 2'b00);
    assign bus.req_ready = grant_now ? (gnt ? 2'b10 : 2'b01) : 2'b00;

    assign sel_chip  = bus.req_chip[gnt];
    assign sel_rnw   = bus.req_rnw[gnt];
    assign sel_addr  = gnt ? bus.req_addr[19:10]  : bus.req_addr[9:0];
    assign sel_wdata = gnt ? bus.req_wdata[15:8]  : bus.req_wdata[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            ptr         <= 1'b0;
            gnt_id      <= 1'b0;
            chip        <= 1'b0;
            rnw         <= 1'b0;
            shreg       <= '0;
            rdata       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_now) begin
                        gnt_id <= gnt;
                        ptr    <= ~gnt;
                        chip   <= sel_chip;
                        rnw    <= sel_rnw;
                        shreg  <= {~sel_rnw, 5'b00000, sel_addr, sel_rnw ? 8'h00 : sel_wdata};
                        cnt    <= '0;
                        state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == CW'(CS_SETUP - 1)) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= S_SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    // First high-phase cycle: the chip's DO has been stable since the falling edge.
                    if (cnt == CW'(CLK_DIV) && bit_cnt >= CW'(16))
                        rdata <= {rdata[6:0], sdo};
                    if (cnt == CW'(2 * CLK_DIV - 1)) begin
                        cnt   <= '0;
                        shreg <= {shreg[22:0], 1'b0};
                        if (bit_cnt == CW'(23)) state <= S_HOLD;
                        else                    bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt == CW'(CS_HOLD - 1)) begin
                        cnt         <= '0;
                        state       <= S_GAP;
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= gnt_id;
                        rsp_data_q  <= rnw ? rdata : 8'h00;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt == CW'(CS_GAP - 1)) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign active  = (state == S_SETUP) || (state == S_SHIFT) || (state == S_HOLD);
    assign sck_int = (state == S_SHIFT) && (cnt >= CW'(CLK_DIV));
    assign di_int  = ((state == S_SETUP) || (state == S_SHIFT)) && shreg[23];
    assign sdo     = chip ? b_spi_do : a_spi_do;

    // The unaddressed chip is held fully idle.
    assign a_spi_cs  = ~(active && !chip);
    assign a_spi_sck = sck_int && !chip;
    assign a_spi_di  = di_int && !chip;
    assign b_spi_cs  = ~(active && chip);
    assign b_spi_sck = sck_int && chip;
    assign b_spi_di  = di_int && chip;

    assign bus.busy      = (state != S_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign state_dbg     = state;
endmodule

// File: tb/tb_ad9361_spi_sched.sv
// Bench for ad9361_spi_sched: cycle-level timing model, chip models on both
// SPI ports, table vectors, arbitration/reset/pulse sequences and random commands.
`timescale 1ns/1ps
module tb_ad9361_spi_sched;
    localparam int CLK_DIV  = 4;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int CS_GAP   = 4;
    localparam int T_SHIFT0 = 1 + CS_SETUP;
    localparam int T_RSP    = 1 + CS_SETUP + 48 * CLK_DIV + CS_HOLD;
    localparam int T_IDLE   = T_RSP + CS_GAP;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ad9361_spi_sched_if bus();
    logic a_sck, a_di, a_cs, a_do, b_sck, b_di, b_cs, b_do;
    logic [2:0] state_dbg;

    logic       rv     [2];
    logic       r_chip [2];
    logic       r_rnw  [2];
    logic [9:0] r_addr [2];
    logic [7:0] r_wd   [2];
    logic [7:0] a_ret = 8'h00;
    logic [7:0] b_ret = 8'h00;

    assign bus.req_valid = {rv[1], rv[0]};
    assign bus.req_chip  = {r_chip[1], r_chip[0]};
    assign bus.req_rnw   = {r_rnw[1], r_rnw[0]};
    assign bus.req_addr  = {r_addr[1], r_addr[0]};
    assign bus.req_wdata = {r_wd[1], r_wd[0]};

    ad9361_spi_sched #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .a_spi_sck(a_sck), .a_spi_di(a_di), .a_spi_cs(a_cs), .a_spi_do(a_do),
        .b_spi_sck(b_sck), .b_spi_di(b_di), .b_spi_cs(b_cs), .b_spi_do(b_do),
        .state_dbg(state_dbg)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one transaction at a time, timed as offsets from its grant.
    bit         m_act = 0;
    int         m_k = 0;
    bit         m_ptr = 0;
    bit         m_g;
    bit         m_id, m_chip;
    logic [23:0] m_frame;
    logic [7:0] m_rsp;
    bit         m_out_id = 0;
    logic [7:0] m_out_data = 8'h00;

    function automatic bit pick(input logic [1:0] v, input bit p);
        if (v == 2'b11) return p;
        return v[1];
    endfunction

    function automatic logic [23:0] frame_of(input bit rnw, input logic [9:0] addr, input logic [7:0] wd);
        return {~rnw, 5'b00000, addr, rnw ? 8'h00 : wd};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_act = 0; m_k = 0; m_ptr = 0; m_out_id = 0; m_out_data = 8'h00;
        end else if (!m_act) begin
            if (bus.req_valid != 2'b00) begin
                m_g     = pick(bus.req_valid, m_ptr);
                m_ptr   = !m_g;
                m_id    = m_g;
                m_chip  = r_chip[m_g];
                m_frame = frame_of(r_rnw[m_g], r_addr[m_g], r_wd[m_g]);
                m_rsp   = r_rnw[m_g] ? (r_chip[m_g] ? b_ret : a_ret) : 8'h00;
                m_act   = 1;
                m_k     = 1;
            end
        end else begin
            m_k++;
            if (m_k == T_RSP) begin
                m_out_id = m_id; m_out_data = m_rsp;
            end
            if (m_k == T_IDLE) m_act = 0;
        end
    end

    function automatic logic [2:0] exp_pins(input bit sel);
        int off;
        if (!m_act || m_chip != sel || m_k >= T_RSP) return 3'b100;
        if (m_k < T_SHIFT0) return {2'b00, m_frame[23]};
        if (m_k >= T_SHIFT0 + 48 * CLK_DIV) return 3'b000;
        off = m_k - T_SHIFT0;
        return {1'b0, (off % (2 * CLK_DIV)) >= CLK_DIV, m_frame[23 - off / (2 * CLK_DIV)]};
    endfunction

    function automatic logic [1:0] exp_ready();
        if (m_act || rst || bus.req_valid == 2'b00) return 2'b00;
        return pick(bus.req_valid, m_ptr) ? 2'b10 : 2'b01;
    endfunction

    // Monitor / chip models / scoreboard logs
    logic [31:0] frame_q[$];
    logic [7:0]  exp_q[$];
    bit          rsp_id_q[$];
    logic [7:0]  rsp_data_q[$];
    int          rsp_lat_q[$];
    bit          grant_q[$];
    int          last_grant = 0;
    int          a_falls = 0, b_falls = 0, a_n = 0, b_n = 0;
    logic [23:0] a_cap = '0, b_cap = '0;
    logic        a_sck_q = 0, b_sck_q = 0, a_cs_q = 1, b_cs_q = 1;
    int          hi_run = 0;
    int          min_gap = 1000;
    bit          seen_txn = 0;
    logic [18:0] exp_v, act_v;

    always @(negedge clk) begin
        if (cyc > 0) begin
            exp_v = {exp_ready(), m_act, (m_act && m_k == T_RSP), m_out_id, m_out_data, exp_pins(0), exp_pins(1)};
            act_v = {bus.req_ready, bus.busy, bus.rsp_valid, bus.rsp_id, bus.rsp_data,
                     a_cs, a_sck, a_di, b_cs, b_sck, b_di};
            n_vec++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL pins: got %05h expected %05h (cycle %0d, k=%0d)", act_v, exp_v, cyc, m_k);
            end
        end
        if (a_cs_q && !a_cs) begin a_falls = 0; a_n = 0; a_cap = '0; end
        else if (a_sck_q && !a_sck) a_falls++;
        if (b_cs_q && !b_cs) begin b_falls = 0; b_n = 0; b_cap = '0; end
        else if (b_sck_q && !b_sck) b_falls++;
        a_do = (a_falls >= 16 && a_falls < 24) ? a_ret[23 - a_falls] : 1'b0;
        b_do = (b_falls >= 16 && b_falls < 24) ? b_ret[23 - b_falls] : 1'b0;
        if (!a_sck_q && a_sck) begin a_cap = {a_cap[22:0], a_di}; a_n++; end
        if (!b_sck_q && b_sck) begin b_cap = {b_cap[22:0], b_di}; b_n++; end
        if (!a_cs_q && a_cs) frame_q.push_back({1'b0, 7'(a_n), a_cap});
        if (!b_cs_q && b_cs) frame_q.push_back({1'b1, 7'(b_n), b_cap});
        if (rst) seen_txn = 0;
        if (!a_cs || !b_cs) begin
            if (hi_run > 0 && seen_txn && hi_run < min_gap) min_gap = hi_run;
            hi_run = 0; seen_txn = 1;
        end else hi_run++;
        if (bus.req_ready[0]) begin grant_q.push_back(1'b0); last_grant = cyc; end
        if (bus.req_ready[1]) begin grant_q.push_back(1'b1); last_grant = cyc; end
        if (bus.rsp_valid) begin
            rsp_id_q.push_back(bus.rsp_id); rsp_data_q.push_back(bus.rsp_data);
            rsp_lat_q.push_back(cyc - last_grant);
        end
        a_sck_q = a_sck; b_sck_q = b_sck; a_cs_q = a_cs; b_cs_q = b_cs;
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_logs();
        frame_q.delete(); rsp_id_q.delete(); rsp_data_q.delete(); rsp_lat_q.delete(); grant_q.delete();
    endtask

    task automatic issue(input bit id, input bit chip, input bit rnw, input logic [9:0] addr, input logic [7:0] wd);
        bit granted = 0;
        int t = 0;
        r_chip[id] = chip; r_rnw[id] = rnw; r_addr[id] = addr; r_wd[id] = wd; rv[id] = 1'b1;
        while (!granted && t < 2000) begin
            @(negedge clk);
            if (bus.req_ready[id]) granted = 1; else t++;
        end
        check($sformatf("grant_req%0d", id), 32'(granted), 32'd1);
        @(posedge clk); #1;
        rv[id] = 1'b0;
        r_addr[id] = 10'($urandom); r_wd[id] = 8'($urandom); r_rnw[id] = 1'($urandom);
    endtask

    task automatic wait_rsps(input int n);
        int t = 0;
        while (rsp_id_q.size() < n && t < 1000) begin tick(1); t++; end
        check("rsp_count", 32'(rsp_id_q.size()), 32'(n));
    endtask

    task automatic run_txn(input bit id, input bit chip, input bit rnw, input logic [9:0] addr,
                           input logic [7:0] wd, input logic [23:0] efr, input logic [7:0] edata);
        logic [31:0] f;
        clear_logs();
        issue(id, chip, rnw, addr, wd);
        wait_rsps(1);
        if (rsp_id_q.size() > 0) begin
            check("rsp_id", 32'(rsp_id_q[0]), 32'(id));
            check("rsp_data", 32'(rsp_data_q[0]), 32'(edata));
            check("latency", 32'(rsp_lat_q[0]), 32'(T_RSP));
        end
        check("frame_count", 32'(frame_q.size()), 32'd1);
        if (frame_q.size() > 0) begin
            f = frame_q[0];
            check("frame_chip", 32'(f[31]), 32'(chip));
            check("frame_bits", 32'(f[30:24]), 32'd24);
            check("frame_di", 32'(f[23:0]), 32'(efr));
        end
        tick(CS_GAP + 2);
    endtask

    typedef struct {
        bit         id;
        bit         chip;
        bit         rnw;
        logic [9:0] addr;
        logic [7:0] wdata;
        logic [7:0] ret;
        logic [23:0] exp_frame;
        logic [7:0] exp_data;
    } vec_t;

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[4];
        bit   order[4];
        for (int i = 0; i < 2; i++) begin
            rv[i] = 0; r_chip[i] = 0; r_rnw[i] = 0; r_addr[i] = '0; r_wd[i] = '0;
        end
        vecs[0] = '{1'b0, 1'b0, 1'b0, 10'h037, 8'hA5, 8'h00, 24'h8037A5, 8'h00};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 10'h017, 8'hFF, 8'h3C, 24'h001700, 8'h3C};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 10'h3FF, 8'h5A, 8'h77, 24'h83FF5A, 8'h00};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 10'h200, 8'h00, 8'h81, 24'h020000, 8'h81};
        order[0] = 0; order[1] = 1; order[2] = 0; order[3] = 1;

        tick(3);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_pins", {26'd0, a_cs, a_sck, a_di, b_cs, b_sck, b_di}, 32'b100100);
        rst = 0;
        tick(2);

        // table vectors
        for (int i = 0; i < 4; i++) begin
            a_ret = vecs[i].chip ? 8'($urandom) : vecs[i].ret;
            b_ret = vecs[i].chip ? vecs[i].ret : 8'($urandom);
            run_txn(vecs[i].id, vecs[i].chip, vecs[i].rnw, vecs[i].addr, vecs[i].wdata,
                    vecs[i].exp_frame, vecs[i].exp_data);
        end

        // both requesters valid right after reset: strict alternation
        rst = 1; tick(2); rst = 0;
        clear_logs(); min_gap = 1000;
        fork
            begin issue(0, 0, 0, 10'h101, 8'h11); issue(0, 1, 1, 10'h102, 8'h22); end
            begin issue(1, 1, 0, 10'h201, 8'h33); issue(1, 0, 1, 10'h202, 8'h44); end
        join
        wait_rsps(4);
        check("grant_count", 32'(grant_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < grant_q.size()) check($sformatf("grant_order%0d", i), 32'(grant_q[i]), 32'(order[i]));
        check("cs_gap_min_ok", 32'(min_gap >= CS_GAP), 32'd1);
        tick(CS_GAP + 2);

        // reset in the middle of SHIFT bit 10 abandons the transaction
        clear_logs();
        issue(0, 0, 0, 10'h0AA, 8'hC3);
        tick(T_SHIFT0 + 10 * 2 * CLK_DIV - 1);
        rst = 1; tick(1);
        check("abort_pins", {29'd0, a_cs, a_sck, bus.busy}, 32'b100);
        rst = 0;
        tick(250);
        check("abort_no_rsp", 32'(rsp_id_q.size()), 32'd0);
        clear_logs();
        fork
            issue(0, 1, 1, 10'h155, 8'h00);
            issue(1, 0, 0, 10'h2AA, 8'h66);
        join
        wait_rsps(2);
        if (grant_q.size() > 0) check("after_reset_first_grant", 32'(grant_q[0]), 32'd0);
        if (rsp_id_q.size() > 0) check("after_reset_first_rsp", 32'(rsp_id_q[0]), 32'd0);
        tick(CS_GAP + 2);

        // one-cycle req_valid[0] pulse while busy is never serviced
        clear_logs();
        issue(1, 1, 0, 10'h3A5, 8'h99);
        tick(20);
        rv[0] = 1; r_chip[0] = 0; r_rnw[0] = 0; tick(1); rv[0] = 0;
        tick(T_IDLE + 100);
        check("pulse_grants", 32'(grant_q.size()), 32'd1);
        check("pulse_rsps", 32'(rsp_id_q.size()), 32'd1);

        // random commands against the model
        for (int i = 0; i < 8; i++) begin
            bit id, chip, rnw;
            logic [9:0] addr;
            logic [7:0] wd;
            id = 1'($urandom); chip = 1'($urandom); rnw = 1'($urandom);
            addr = 10'($urandom); wd = 8'($urandom);
            a_ret = 8'($urandom); b_ret = 8'($urandom);
            exp_q.push_back(rnw ? (chip ? b_ret : a_ret) : 8'h00);
            run_txn(id, chip, rnw, addr, wd, frame_of(rnw, addr, wd), exp_q.pop_front());
            tick($urandom_range(0, 5));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
